// File: rtl/mux8_arb_pkg.sv
// Shared types, constants and helpers for the 8-way round-robin mux arbiter.
package mux8_arb_pkg;

    localparam int unsigned NREQ = 8;
    localparam int unsigned SELW = 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Convert a requester index into a one-hot grant vector.
    function automatic logic [NREQ-1:0] idx_to_onehot(input logic [SELW-1:0] idx);
        return NREQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Rotate-priority encoder: first set req bit at or after ptr, wrapping modulo 8.
module rr_pick8
    import mux8_arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [SELW-1:0] ptr,
    output logic            found,
    output logic [SELW-1:0] idx
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [SELW-1:0]   off;

    assign dbl = {req, req} >> ptr;
    assign rot = dbl[NREQ-1:0];

    // Scan downward so the lowest rotated offset (nearest to ptr) wins.
    always_comb begin
        found = 1'b0;
        off   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                off   = SELW'(i);
            end
        end
    end

    assign idx = ptr + off;

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 bit mux, with per-ownership burst limit.
// Optional owner lock (burst extension) enabled by defining MUX8_ARB_LOCK_EN.
module mux8_rr_arbiter
    import mux8_arb_pkg::*;
#(
    parameter int unsigned BURST_LEN = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] d,
`ifdef MUX8_ARB_LOCK_EN
    input  logic            lock,
`endif
    output logic [NREQ-1:0] gnt,
    output logic [SELW-1:0] s,
    output logic            o,
    output logic            o_vld
);

    localparam int unsigned    CNTW     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(BURST_LEN - 1);
    localparam logic [0:0]      ST_IDLE  = IDLE;
    localparam logic [0:0]      ST_GRANT = GRANT;

    logic [0:0]      state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [SELW-1:0] s_q, s_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [SELW-1:0] ptr_q, ptr_d;
    logic            o_q, o_vld_q;
    logic [SELW-1:0] pick_ptr_c;
    logic            found_c;
    logic [SELW-1:0] idx_c;
    logic            lock_c;
    logic            owner_req_c;

`ifdef MUX8_ARB_LOCK_EN
    assign lock_c = lock;
`else
    assign lock_c = 1'b0;
`endif

    assign owner_req_c = req[s_q];

    // While granting, the search only matters on release, where it starts after the owner.
    assign pick_ptr_c = (state_q == ST_GRANT) ? s_q + SELW'(1) : ptr_q;

    rr_pick8 u_pick (
        .req   (req),
        .ptr   (pick_ptr_c),
        .found (found_c),
        .idx   (idx_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (found_c) begin
                    gnt_d   = idx_to_onehot(idx_c);
                    s_d     = idx_c;
                    cnt_d   = '0;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (owner_req_c && (cnt_q < CNT_MAX)) begin
                    cnt_d = cnt_q + CNTW'(1);
                end else if (owner_req_c && lock_c) begin
                    cnt_d = CNT_MAX;
                end else begin
                    // Release and re-arbitrate in the same cycle; no bubble if anyone waits.
                    ptr_d = s_q + SELW'(1);
                    cnt_d = '0;
                    if (found_c) begin
                        gnt_d = idx_to_onehot(idx_c);
                        s_d   = idx_c;
                    end else begin
                        gnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // Data stage lags the grant by one cycle; o is forced low when nothing was granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_q     <= 1'b0;
            o_vld_q <= 1'b0;
        end else begin
            o_q     <= (|gnt_q) ? d[s_q] : 1'b0;
            o_vld_q <= |gnt_q;
        end
    end

    assign gnt   = gnt_q;
    assign s     = s_q;
    assign o     = o_q;
    assign o_vld = o_vld_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Scoreboarded random/directed bench for mux8_rr_arbiter against a queue-based reference model.
module tb_mux8_rr_arbiter;

    localparam int BL = 4;

    typedef struct {
        logic [7:0] gnt;
        logic [2:0] s;
        logic       o;
        logic       vld;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] d;
    logic       lock;
    logic [7:0] gnt;
    logic [2:0] s;
    logic       o;
    logic       o_vld;

    int errors;
    int checks;
    exp_t exp_q[$];

    // Reference model state: current owner (-1 = none), cycles held, next search start, last select.
    int m_owner;
    int m_used;
    int m_ptr;
    int m_s;

    mux8_rr_arbiter #(.BURST_LEN(BL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .d     (d),
`ifdef MUX8_ARB_LOCK_EN
        .lock  (lock),
`endif
        .gnt   (gnt),
        .s     (s),
        .o     (o),
        .o_vld (o_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_used  = 0;
        m_ptr   = 0;
        m_s     = 0;
    endtask

    // One clock edge of the arbiter, expressed as ownership bookkeeping.
    task automatic model_step(input logic [7:0] r, input logic [7:0] dd, input logic l);
        exp_t e;
        e.vld = (m_owner >= 0);
        e.o   = e.vld ? dd[m_s] : 1'b0;
        if (m_owner >= 0) begin
            if (r[m_owner] && (m_used < BL || l)) begin
                if (m_used < BL) m_used++;
            end else begin
                m_ptr   = (m_owner + 1) % 8;
                m_owner = -1;
            end
        end
        if (m_owner < 0) begin
            for (int k = 0; k < 8; k++) begin
                int idx;
                idx = (m_ptr + k) % 8;
                if (m_owner < 0 && r[idx]) begin
                    m_owner = idx;
                    m_used  = 1;
                    m_s     = idx;
                end
            end
        end
        e.gnt = (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0;
        e.s   = 3'(m_s);
        exp_q.push_back(e);
    endtask

    // Drive inputs for the next edge (caller is at a negedge) and predict the result.
    task automatic step(input logic [7:0] r, input logic l);
        logic le;
        req  = r;
        d    = 8'($urandom);
        lock = l;
`ifdef MUX8_ARB_LOCK_EN
        le = l;
`else
        le = 1'b0;
`endif
        model_step(r, d, le);
    endtask

    task automatic run(input logic [7:0] r, input logic l, input int n);
        repeat (n) begin
            @(negedge clk);
            step(r, l);
        end
    endtask

    // Monitor: every edge with a pending prediction, compare all outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("gnt",   32'(gnt),   32'(e.gnt));
                chk("s",     32'(s),     32'(e.s));
                chk("o",     32'(o),     32'(e.o));
                chk("o_vld", 32'(o_vld), 32'(e.vld));
            end
        end
    end

    initial begin
        logic [7:0] r;
        int guard;
        errors = 0;
        checks = 0;
        model_reset();
        rst_n = 1'b0;
        req   = 8'hFF;
        d     = 8'hFF;
        lock  = 1'b0;

        // Held in reset with all requests up: outputs stay clear.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt",   32'(gnt),   32'h0);
        chk("rst_s",     32'(s),     32'h0);
        chk("rst_o",     32'(o),     32'h0);
        chk("rst_o_vld", 32'(o_vld), 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        step(8'hFF, 1'b0);
        run(8'hFF, 1'b0, 40);           // full rotation, BL cycles each
        run(8'h00, 1'b0, 3);
        run(8'h80, 1'b0, 16);           // sole requester re-granted at expiry
        run(8'h00, 1'b0, 2);
        run(8'h24, 1'b0, 1);            // early drop: 2 then 5
        run(8'h20, 1'b0, 4);
        run(8'h00, 1'b0, 2);
`ifdef MUX8_ARB_LOCK_EN
        run(8'h03, 1'b1, 10);
        run(8'h03, 1'b0, 6);
        run(8'h00, 1'b0, 2);
`endif

        // Randomised traffic with sticky requests.
        r = 8'h00;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 15) == 0) r = 8'h00;
            else r = r ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            @(negedge clk);
            step(r, 1'($urandom_range(0, 3) == 0));
        end

        // Reset in the middle of a grant to requester 5.
        run(8'h00, 1'b0, 2);
        guard = 0;
        do begin
            @(negedge clk);
            step(8'hFF, 1'b0);
            guard++;
        end while (m_owner != 5 && guard < 64);
        chk("reach_owner5", 32'(m_owner), 32'd5);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_gnt",   32'(gnt),   32'h0);
        chk("async_o",     32'(o),     32'h0);
        chk("async_o_vld", 32'(o_vld), 32'h0);
        model_reset();
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(8'hFF, 1'b0);
        run(8'hFF, 1'b0, 6);
        run(8'h00, 1'b0, 3);

        @(posedge clk);
        #2;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
